// File: rtl/ccip_rx_bookkeeper.sv
// RX bookkeeping writer: one eREQ_WRPUSH_I line per accepted RX event, posted on CCI-P channel 1.
// Build option: define CCIP_BK_OVERFLOW_DROP_EN to count full-FIFO drops instead of flagging error.

package ccip_if_pkg;
   typedef logic [41:0]  t_ccip_clAddr;
   typedef logic [511:0] t_ccip_clData;
   typedef enum logic [1:0] {eVC_VA = 2'h0, eVC_VL0 = 2'h1, eVC_VH0 = 2'h2, eVC_VH1 = 2'h3} t_ccip_vc;
   typedef enum logic [1:0] {eCL_LEN_1 = 2'b00, eCL_LEN_2 = 2'b01, eCL_LEN_4 = 2'b11} t_ccip_clLen;
   typedef enum logic [3:0] {eREQ_WRLINE_I = 4'h0, eREQ_WRLINE_M = 4'h1, eREQ_WRPUSH_I = 4'h2,
                             eREQ_WRFENCE = 4'h4, eREQ_INTR = 4'h6} t_ccip_c1_req;

   typedef struct packed {
      logic [5:0]   rsvd2;
      t_ccip_vc     vc_sel;
      logic         sop;
      logic         rsvd1;
      t_ccip_clLen  cl_len;
      t_ccip_c1_req req_type;
      logic [5:0]   rsvd0;
      t_ccip_clAddr address;
      logic [15:0]  mdata;
   } t_ccip_c1_ReqMemHdr;

   typedef struct packed {
      logic [1:0]  vc_used;
      logic        rsvd1;
      logic        hit_miss;
      logic        format;
      logic        rsvd0;
      logic [1:0]  cl_num;
      logic [3:0]  resp_type;
      logic [15:0] mdata;
   } t_ccip_c1_RspMemHdr;

   typedef struct packed {
      t_ccip_c1_ReqMemHdr hdr;
      t_ccip_clData       data;
      logic               valid;
   } t_if_ccip_c1_Tx;

   typedef struct packed {
      t_ccip_c1_RspMemHdr hdr;
      logic               rspValid;
   } t_if_ccip_c1_Rx;
endpackage

// Generic show-ahead FIFO; a write into a full FIFO is accepted only when a read happens in the same cycle.
module ccip_bk_fifo #(
   parameter int W      = 8,
   parameter int LDEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr_vld,
   input  logic [W-1:0] wr_dat,
   input  logic         rd_rdy,
   output logic         rd_vld,
   output logic [W-1:0] rd_dat,
   output logic         full
);
   logic [W-1:0]      mem [1<<LDEPTH];
   logic [LDEPTH-1:0] wr_ptr, rd_ptr;
   logic [LDEPTH:0]   count;
   logic              do_rd, do_wr;

   assign rd_vld = (count != '0);
   assign full   = count[LDEPTH];
   assign rd_dat = mem[rd_ptr];
   assign do_rd  = rd_rdy && rd_vld;
   assign do_wr  = wr_vld && (!full || do_rd);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + LDEPTH'(1);
         if (do_rd) rd_ptr <= rd_ptr + LDEPTH'(1);
         if (do_wr && !do_rd)      count <= count + (LDEPTH+1)'(1);
         else if (!do_wr && do_rd) count <= count - (LDEPTH+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_dat;
   end
endmodule

module ccip_rx_bookkeeper
   import ccip_if_pkg::*;
#(
   parameter int NIC_ID             = 0,
   parameter int LMAX_NUM_OF_FLOWS  = 1,
   parameter int LMAX_RX_QUEUE_SIZE = 1,
   parameter int LMAX_BK_RING_SIZE  = 4,
   parameter int LMAX_EV_FIFO       = 4,
   parameter int MAX_OUTSTANDING    = 8
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic                                 initialize,
   output logic                                 initialized,
   output logic                                 error,
   input  logic [LMAX_NUM_OF_FLOWS-1:0]         number_of_flows,
   input  t_ccip_clAddr                         rx_bk_base_addr,
   input  logic [LMAX_BK_RING_SIZE-1:0]         bk_ring_mask,
   input  logic                                 ev_valid,
   input  logic [LMAX_NUM_OF_FLOWS-1:0]         ev_flow_id,
   input  logic [LMAX_RX_QUEUE_SIZE-1:0]        ev_entry,
   input  logic                                 sRx_c1TxAlmFull,
   input  t_if_ccip_c1_Rx                       sRx_c1,
   output t_if_ccip_c1_Tx                       sTx_c1,
   output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
   output logic [31:0]                          drop_cnt
);
   localparam int LF      = LMAX_NUM_OF_FLOWS;
   localparam int LQ      = LMAX_RX_QUEUE_SIZE;
   localparam int MDATA_W = LF + LQ;
   localparam int NFLOWS  = 1 << LF;
   localparam int OW      = $clog2(MAX_OUTSTANDING) + 1;

   typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN} state_t;

   state_t                       state;
   logic [LF-1:0]                init_idx;
   logic [LMAX_BK_RING_SIZE-1:0] ptr [NFLOWS];
   logic [31:0]                  seq [NFLOWS];

   logic               in_vld;
   logic [MDATA_W-1:0] in_dat;
   logic               bad_flow, fifo_vld, fifo_full, push, pop, ovf, ovf_err, rsp;
   logic [MDATA_W-1:0] fifo_dat;
   logic [LF-1:0]      pop_flow;
   logic [LQ-1:0]      pop_entry;
   logic               unused_ok;

   assign bad_flow  = ev_valid && (ev_flow_id > number_of_flows);
   assign pop_flow  = fifo_dat[LQ +: LF];
   assign pop_entry = fifo_dat[LQ-1:0];
   assign rsp       = sRx_c1.rspValid;
   assign pop       = (state == S_RUN) && start && fifo_vld && !sRx_c1TxAlmFull &&
                      (outstanding < OW'(MAX_OUTSTANDING));
   assign push      = in_vld;
   assign ovf       = in_vld && fifo_full && !pop;
   assign unused_ok = ^{sRx_c1.hdr, 32'(NIC_ID)};

   // Input register gives the FIFO one full cycle before the entry becomes poppable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_vld <= 1'b0;
         in_dat <= '0;
      end else begin
         in_vld <= ev_valid && !bad_flow;
         in_dat <= {ev_flow_id, ev_entry};
      end
   end

   ccip_bk_fifo #(.W(MDATA_W), .LDEPTH(LMAX_EV_FIFO)) u_ev_fifo (
      .clk    (clk),
      .reset  (reset),
      .wr_vld (push),
      .wr_dat (in_dat),
      .rd_rdy (pop),
      .rd_vld (fifo_vld),
      .rd_dat (fifo_dat),
      .full   (fifo_full)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         init_idx    <= '0;
         initialized <= 1'b0;
         for (int i = 0; i < NFLOWS; i++) begin
            ptr[i] <= '0;
            seq[i] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: if (initialize && !initialized) begin
               state    <= S_INIT;
               init_idx <= '0;
            end
            S_INIT: begin
               ptr[init_idx] <= '0;
               seq[init_idx] <= '0;
               init_idx      <= init_idx + LF'(1);
               if (init_idx == LF'(NFLOWS - 1)) begin
                  state       <= S_RUN;
                  initialized <= 1'b1;
               end
            end
            S_RUN: if (pop) begin
               ptr[pop_flow] <= (ptr[pop_flow] + LMAX_BK_RING_SIZE'(1)) & bk_ring_mask;
               seq[pop_flow] <= seq[pop_flow] + 32'd1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sTx_c1 <= '0;
      end else begin
         sTx_c1.valid <= pop;
         if (pop) begin
            sTx_c1.hdr          <= '0;
            sTx_c1.hdr.sop      <= 1'b1;
            sTx_c1.hdr.vc_sel   <= eVC_VH0;
            sTx_c1.hdr.req_type <= eREQ_WRPUSH_I;
            sTx_c1.hdr.cl_len   <= eCL_LEN_1;
            sTx_c1.hdr.address  <= rx_bk_base_addr
                                   + (t_ccip_clAddr'(pop_flow) << LMAX_BK_RING_SIZE)
                                   + t_ccip_clAddr'(ptr[pop_flow]);
            sTx_c1.data         <= '0;
            sTx_c1.data[15:0]   <= 16'(pop_entry);
            sTx_c1.data[31:16]  <= 16'(pop_flow);
            sTx_c1.data[63:32]  <= seq[pop_flow];
         end
      end
   end

   // A response while nothing is in flight is a protocol fault; the counter holds at zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         outstanding <= '0;
         error       <= 1'b0;
      end else begin
         if (pop && !rsp)                               outstanding <= outstanding + OW'(1);
         else if (!pop && rsp && outstanding != '0)     outstanding <= outstanding - OW'(1);
         if (bad_flow || ovf_err || (rsp && !pop && outstanding == '0)) error <= 1'b1;
      end
   end

`ifdef CCIP_BK_OVERFLOW_DROP_EN
   assign ovf_err = 1'b0;
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                        drop_cnt <= '0;
      else if (ovf && drop_cnt != '1)   drop_cnt <= drop_cnt + 32'd1;
   end
`else
   assign ovf_err  = ovf;
   assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_ccip_rx_bookkeeper.sv
// Bench for ccip_rx_bookkeeper: scoreboard of expected write lines plus directed flag/counter checks.
module tb_ccip_rx_bookkeeper;
   import ccip_if_pkg::*;

   typedef struct packed {
      t_ccip_c1_ReqMemHdr hdr;
      logic [63:0]        data;
   } exp_t;

   logic           clk = 1'b0;
   logic           reset, start, initialize, ev_valid, almfull;
   logic           initialized, error;
   logic [0:0]     number_of_flows, ev_flow_id;
   logic [3:0]     ev_entry, bk_ring_mask;
   t_ccip_clAddr   base;
   t_if_ccip_c1_Rx rx;
   t_if_ccip_c1_Tx tx;
   logic [3:0]     outstanding;
   logic [31:0]    drop_cnt;

   logic           ev2_valid, initialized2, error2;
   t_if_ccip_c1_Tx tx2;
   logic [3:0]     outstanding2;
   logic [31:0]    drop_cnt2;
   t_if_ccip_c1_Rx rx2;

   int compared = 0, mismatched = 0, wr_count = 0, cyc = 0, pend = 0, rsp_allow = 100000;
   exp_t sb[$];
   int   wcyc[$];
   logic [3:0]  m_ptr [2];
   logic [31:0] m_seq [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   ccip_rx_bookkeeper #(.NIC_ID(0), .LMAX_NUM_OF_FLOWS(1), .LMAX_RX_QUEUE_SIZE(4),
                        .LMAX_BK_RING_SIZE(4), .LMAX_EV_FIFO(4), .MAX_OUTSTANDING(8)) dut (
      .clk(clk), .reset(reset), .start(start), .initialize(initialize),
      .initialized(initialized), .error(error), .number_of_flows(number_of_flows),
      .rx_bk_base_addr(base), .bk_ring_mask(bk_ring_mask), .ev_valid(ev_valid),
      .ev_flow_id(ev_flow_id), .ev_entry(ev_entry), .sRx_c1TxAlmFull(almfull),
      .sRx_c1(rx), .sTx_c1(tx), .outstanding(outstanding), .drop_cnt(drop_cnt));

   ccip_rx_bookkeeper #(.NIC_ID(1), .LMAX_NUM_OF_FLOWS(1), .LMAX_RX_QUEUE_SIZE(4),
                        .LMAX_BK_RING_SIZE(4), .LMAX_EV_FIFO(2), .MAX_OUTSTANDING(8)) dut_ovf (
      .clk(clk), .reset(reset), .start(1'b0), .initialize(1'b0),
      .initialized(initialized2), .error(error2), .number_of_flows(1'b1),
      .rx_bk_base_addr(base), .bk_ring_mask(bk_ring_mask), .ev_valid(ev2_valid),
      .ev_flow_id(1'b0), .ev_entry(ev_entry), .sRx_c1TxAlmFull(1'b0),
      .sRx_c1(rx2), .sTx_c1(tx2), .outstanding(outstanding2), .drop_cnt(drop_cnt2));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Expected line for the next write of flow f, from the bench's own ring/seq model.
   task automatic expect_write(input logic [0:0] f, input logic [3:0] e);
      exp_t x;
      x.hdr          = '0;
      x.hdr.sop      = 1'b1;
      x.hdr.vc_sel   = eVC_VH0;
      x.hdr.req_type = eREQ_WRPUSH_I;
      x.hdr.cl_len   = eCL_LEN_1;
      x.hdr.address  = 42'h1000 + (42'(f) << 4) + 42'(m_ptr[f]);
      x.data         = {m_seq[f], 15'd0, f, 12'd0, e};
      m_ptr[f]       = (m_ptr[f] + 4'd1) & 4'hF;
      m_seq[f]       = m_seq[f] + 32'd1;
      sb.push_back(x);
   endtask

   task automatic send(input logic [0:0] f, input logic [3:0] e, input bit will_write);
      ev_valid   = 1'b1;
      ev_flow_id = f;
      ev_entry   = e;
      if (will_write) expect_write(f, e);
      @(posedge clk); #1;
      ev_valid = 1'b0;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin m_ptr[i] = '0; m_seq[i] = '0; end
   endtask

   always @(negedge clk) begin
      if (reset === 1'b0 && tx.valid === 1'b1) begin
         exp_t x;
         wr_count++;
         wcyc.push_back(cyc);
         pend++;
         compared++;
         if (sb.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                     tx.hdr.address, tx.data[63:0]);
         end else begin
            x = sb.pop_front();
            if (tx.hdr !== x.hdr || tx.data[63:0] !== x.data || tx.data[511:64] !== '0) begin
               mismatched++;
               $display("FAIL write_line: hdr 0x%0h data 0x%0h, expected hdr 0x%0h data 0x%0h",
                        tx.hdr, tx.data[63:0], x.hdr, x.data);
            end
         end
      end
   end

   always begin
      @(posedge clk); #1;
      rx.hdr = '0;
      if (pend > 0 && rsp_allow > 0) begin
         rx.rspValid = 1'b1;
         pend--;
         rsp_allow--;
      end else begin
         rx.rspValid = 1'b0;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w0, n;
      rx2 = '0;
      reset = 1'b1; start = 1'b0; initialize = 1'b0; ev_valid = 1'b0; ev2_valid = 1'b0;
      almfull = 1'b0; number_of_flows = 1'b1; ev_flow_id = '0; ev_entry = '0;
      base = 42'h1000; bk_ring_mask = 4'hF;
      model_clear();
      cycles(3);
      chk("rst_initialized", initialized, 0);
      chk("rst_error", error, 0);
      chk("rst_valid", tx.valid, 0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      reset = 1'b0;
      cycles(2);

      // Pointer-table clear: two flows, one per cycle.
      initialize = 1'b1;
      cycles(1);
      initialize = 1'b0;
      chk("init_after_1", initialized, 0);
      cycles(1);
      chk("init_after_2", initialized, 0);
      cycles(1);
      chk("init_done", initialized, 1);

      // Single write and its latency.
      start = 1'b1;
      send(1'b1, 4'd3, 1'b1);
      chk("lat_e0", tx.valid, 0);
      cycles(1);
      chk("lat_e1", tx.valid, 0);
      cycles(1);
      chk("lat_e2", tx.valid, 1);
      chk("lat_e2_addr", tx.hdr.address, 42'h1010);
      cycles(1);
      chk("lat_one_cycle", tx.valid, 0);
      cycles(4);

      // Ring wrap on flow 0.
      for (int i = 0; i < 17; i++) send(1'b0, 4'(i), 1'b1);
      cycles(8);
      chk("wrap_sb_empty", sb.size(), 0);

      // Almost-full backpressure.
      almfull = 1'b1;
      w0 = wr_count;
      for (int i = 0; i < 5; i++) send(1'b1, 4'(i), 1'b1);
      cycles(6);
      chk("almfull_hold", wr_count - w0, 0);
      wcyc.delete();
      almfull = 1'b0;
      cycles(10);
      chk("almfull_release", wr_count - w0, 5);
      chk("almfull_back2back", (wcyc.size() == 5) ? wcyc[4] - wcyc[0] : -1, 4);

      // Credit limit.
      cycles(10);
      chk("credit_drained", outstanding, 0);
      rsp_allow = 0;
      w0 = wr_count;
      for (int i = 0; i < 10; i++) send(1'b0, 4'(i), 1'b1);
      cycles(20);
      chk("credit_cap_writes", wr_count - w0, 8);
      chk("credit_cap_outstanding", outstanding, 8);
      rsp_allow = 2;
      cycles(15);
      chk("credit_resume_writes", wr_count - w0, 10);
      chk("credit_resume_outstanding", outstanding, 8);
      rsp_allow = 100000;
      cycles(25);
      chk("credit_final_outstanding", outstanding, 0);

      // FIFO overflow on the shallow instance.
      for (int i = 0; i < 6; i++) begin
         ev2_valid = 1'b1;
         cycles(1);
      end
      ev2_valid = 1'b0;
      cycles(3);
`ifdef CCIP_BK_OVERFLOW_DROP_EN
      chk("ovf_drop_cnt", drop_cnt2, 2);
      chk("ovf_error", error2, 0);
`else
      chk("ovf_drop_cnt", drop_cnt2, 0);
      chk("ovf_error", error2, 1);
`endif

      // Out-of-range flow.
      chk("pre_badflow_error", error, 0);
      number_of_flows = 1'b0;
      w0 = wr_count;
      send(1'b1, 4'd5, 1'b0);
      cycles(6);
      chk("badflow_error", error, 1);
      chk("badflow_no_write", wr_count - w0, 0);
      number_of_flows = 1'b1;

      // Reset with events queued.
      start = 1'b0;
      for (int i = 0; i < 3; i++) send(1'b0, 4'(i), 1'b0);
      cycles(2);
      reset = 1'b1;
      #1;
      chk("arst_error", error, 0);
      chk("arst_initialized", initialized, 0);
      chk("arst_valid", tx.valid, 0);
      chk("arst_outstanding", outstanding, 0);
      chk("arst_drop_cnt", drop_cnt, 0);
      cycles(2);
      reset = 1'b0;
      model_clear();
      w0 = wr_count;
      initialize = 1'b1;
      cycles(1);
      initialize = 1'b0;
      start = 1'b1;
      cycles(12);
      chk("rst_reinit", initialized, 1);
      chk("rst_fifo_cleared", wr_count - w0, 0);

      // A response with nothing in flight.
      pend = 1;
      cycles(4);
      chk("stray_rsp_outstanding", outstanding, 0);
      chk("stray_rsp_error", error, 1);

      n = sb.size();
      chk("sb_final_empty", n, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/ccip_rx_bookkeeper.md
# ccip_rx_bookkeeper

Downstream companion of the CPU-NIC polling stage. It consumes each accepted RX event (flow id, ring entry index) and reports it back to host memory as one bookkeeping cache line per event, written with eREQ_WRPUSH_I on CCI-P channel 1. The host uses these lines to reclaim RX ring slots. The block buffers events in a FIFO because the upstream stage has no backpressure, and it rate-limits writes on almost-full and on outstanding-write credit.

## Interface
- NIC_ID, 0, NIC index for debug prints
- LMAX_NUM_OF_FLOWS, 1, log2 of max flows
- LMAX_RX_QUEUE_SIZE, 1, log2 of RX ring depth per flow; MDATA_W = LMAX_NUM_OF_FLOWS + LMAX_RX_QUEUE_SIZE
- LMAX_BK_RING_SIZE, 4, log2 of max bookkeeping lines per flow
- LMAX_EV_FIFO, 4, log2 of event FIFO depth
- MAX_OUTSTANDING, 8, max in-flight channel-1 writes
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  enables issuing writes
- initialize  in  1  starts pointer-table clear
- initialized  out  1  pointer table cleared; reset 0
- error  out  1  sticky fault flag; reset 0
- number_of_flows  in  LMAX_NUM_OF_FLOWS  highest valid flow id
- rx_bk_base_addr  in  t_ccip_clAddr  bookkeeping region base (CL address)
- bk_ring_mask  in  LMAX_BK_RING_SIZE  per-flow ring wrap mask (2^k-1)
- ev_valid  in  1  event strobe, from rpc_out_valid
- ev_flow_id  in  LMAX_NUM_OF_FLOWS  event flow
- ev_entry  in  LMAX_RX_QUEUE_SIZE  event ring entry index
- sRx_c1TxAlmFull  in  1  channel-1 almost full
- sRx_c1  in  t_if_ccip_c1_Rx  write responses (rspValid used)
- sTx_c1  out  t_if_ccip_c1_Tx  bookkeeping writes; valid reset 0
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  in-flight writes; reset 0
- drop_cnt  out  32  dropped events (macro-dependent); reset 0

## Operation
- FSM states:
  - Idle → Init when initialize && !initialized.
  - Init clears one per-flow pointer per cycle, flow 0..2^LMAX_NUM_OF_FLOWS-1. After the last flow it goes to Run and sets initialized.
  - Run is terminal until reset.
- Events are accepted into the FIFO in any state.
- ev_flow_id > number_of_flows: event discarded, error set, FIFO untouched.
- Pop condition: state==Run && start && FIFO nonempty && !sRx_c1TxAlmFull && outstanding < MAX_OUTSTANDING.
- On pop, for flow f with pointer p:
  - address = rx_bk_base_addr + (f << LMAX_BK_RING_SIZE) + p
  - p ← (p+1) & bk_ring_mask
  - seq ← seq+1; 32-bit, wraps
- sTx_c1.hdr: zeroed, then sop=1, vc_sel=eVC_VH0, req_type=eREQ_WRPUSH_I, cl_len=eCL_LEN_1.
- sTx_c1.data:
  - [15:0] = ev_entry, zero-extended
  - [31:16] = flow, zero-extended
  - [63:32] = seq value before increment
  - all other bits 0
- Outstanding counter:
  - +1 on issue, -1 on sRx_c1.rspValid.
  - Simultaneous issue and response: unchanged.
  - Decrement saturates at 0; a response with count 0 sets error.

## Timing
- Event sampled at edge E0, FIFO visible at E1, sTx_c1.valid asserted for one cycle after edge E2 (2-cycle minimum latency).
- At most one write per cycle. Back-to-back pops are allowed.
- sRx_c1TxAlmFull is sampled in the pop cycle. A write already registered is not retracted.
- FIFO full with ev_valid: behaviour per Configuration. A simultaneous pop frees a slot, so the event is accepted.
- Reset mid-operation:
  - FIFO, pointers, seq, outstanding, drop_cnt, error, initialized, and FSM all clear asynchronously.
  - Responses arriving after reset follow the saturation rule.
- start deasserted: events keep queuing and no writes issue.

## Configuration
- CCIP_BK_OVERFLOW_DROP_EN defined: an event arriving at a full FIFO is dropped, drop_cnt increments (saturating at 2^32-1), and error is not set.
- CCIP_BK_OVERFLOW_DROP_EN undefined: the event is dropped and error is set. drop_cnt is tied to 0.

## Test plan
- Init and single write: with LMAX_NUM_OF_FLOWS=1, pulse initialize → initialized rises after 2 cycles. Then base=0x1000, mask=0xF, start=1, one event (flow 1, entry 3) → one write at 0x1010 with data[15:0]=3, [31:16]=1, [63:32]=0, 2 cycles after ev_valid.
- Pointer wrap: 17 events on flow 0 with mask=0xF → addresses 0x1000..0x100F, then 0x1000. seq runs 0..16.
- Backpressure: hold sRx_c1TxAlmFull high, send 5 events → no valid. Release it → 5 writes on consecutive cycles, in order.
- Credit limit: MAX_OUTSTANDING=8, withhold responses, send 10 events → exactly 8 writes and outstanding=8. Send 2 responses → remaining 2 writes issue.
- Overflow: LMAX_EV_FIFO=2, start=0, send 6 events → with macro, drop_cnt=2 and error=0; without macro, error=1.
- Bad flow / reset: event with flow > number_of_flows → error=1, no write. Assert reset with 3 events queued → no further writes, all outputs return to reset values.
